// File: rtl/rectangle_pkg.sv
// Shared definitions for the RECTANGLE-80 forward key schedule:
// round-constant seed, default update count, FSM states and forward S-box.
package rectangle_pkg;

  localparam int         NR_DEFAULT = 25;
  localparam logic [4:0] RC_INIT    = 5'h01;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Forward S-box, entry 0 is the rightmost nibble.
  localparam logic [15:0][3:0] SBOX_ENC = {
    4'h2, 4'h4, 4'hF, 4'h8, 4'hD, 4'h3, 4'h0, 4'hB,
    4'h9, 4'h7, 4'hE, 4'h1, 4'hA, 4'hC, 4'h5, 4'h6
  };

  // 5-bit round-constant LFSR step.
  function automatic logic [4:0] rc_next(input logic [4:0] rc);
    return {rc[3:0], rc[4] ^ rc[2]};
  endfunction

endpackage

// File: rtl/rectangle_key_sched_enc_sbox.sv
// Single-column forward S-box of the key update (purely combinational).
module sbox_enc
  import rectangle_pkg::*;
(
  input  logic [3:0] i_x,
  output logic [3:0] o_y
);

  assign o_y = SBOX_ENC[i_x];

endmodule

// File: rtl/rectangle_key_sched_enc.sv
// RECTANGLE-80 iterative forward key schedule: loads an 80-bit key and hands
// out NR+1 round keys (low 64 bits of the evolving key) under valid/ready.
// Optional macro RECT_FINAL_KEY_EN adds final_key/final_valid, capturing the
// key after the last update to seed the decryption schedule.
module rectangle_key_sched_enc
  import rectangle_pkg::*;
#(
  parameter int NR = NR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [79:0] key_in,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [63:0] rk,
  output logic [4:0]  rk_idx,
  output logic        busy,
`ifdef RECT_FINAL_KEY_EN
  output logic [79:0] final_key,
  output logic        final_valid,
`endif
  output logic        done
);

  localparam logic [4:0] NR_IDX = 5'(NR);

  state_t           r_state, w_state_nxt;
  logic [79:0]      r_key;
  logic [4:0]       r_rc;
  logic [4:0]       r_idx;
  logic             w_load, w_step;
  logic [3:0][3:0]  w_sb_in, w_sb_out;
  logic [4:0][15:0] w_rows, w_nxt;
  logic [15:0]      w_r0, w_r3;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and datapath controls; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      IDLE: if (start) begin
        w_load      = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: if (rk_ready) begin
        if (r_idx < NR_IDX) w_step      = 1'b1;
        else                w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Columns {row3[j],row2[j],row1[j],row0[j]} through the S-box.
  for (genvar j = 0; j < 4; j++) begin : g_col
    assign w_sb_in[j] = {r_key[48+j], r_key[32+j], r_key[16+j], r_key[j]};
    sbox_enc u_sbox (.i_x(w_sb_in[j]), .o_y(w_sb_out[j]));
  end

  // Key update: S-box on columns 0..3, generalised Feistel, round constant.
  always_comb begin
    w_rows = r_key;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++)
        w_rows[i][j] = w_sb_out[j][i];
    w_r0      = {w_rows[0][7:0], w_rows[0][15:8]} ^ w_rows[1];
    w_r0[4:0] = w_r0[4:0] ^ r_rc;
    w_r3      = {w_rows[3][3:0], w_rows[3][15:4]} ^ w_rows[4];
    w_nxt     = {w_rows[0], w_r3, w_rows[3], w_rows[2], w_r0};
  end

  // Key, round constant and index; they only move on load or accepted step,
  // so outputs hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key <= '0;
      r_rc  <= RC_INIT;
      r_idx <= '0;
    end else if (w_load) begin
      r_key <= key_in;
      r_rc  <= RC_INIT;
      r_idx <= '0;
    end else if (w_step) begin
      r_key <= w_nxt;
      r_rc  <= rc_next(r_rc);
      r_idx <= r_idx + 5'd1;
    end
  end

  assign rk_valid = (r_state == RUN);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign rk       = r_key[63:0];
  assign rk_idx   = r_idx;

`ifdef RECT_FINAL_KEY_EN
  logic        w_last;
  logic [79:0] r_final_key;
  logic        r_final_valid;

  assign w_last = w_step && (r_idx == NR_IDX - 5'd1);

  // Capture the fully advanced key on the last update; cleared by a new load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_final_key   <= '0;
      r_final_valid <= 1'b0;
    end else if (w_load) begin
      r_final_key   <= '0;
      r_final_valid <= 1'b0;
    end else if (w_last) begin
      r_final_key   <= w_nxt;
      r_final_valid <= 1'b1;
    end
  end

  assign final_key   = r_final_key;
  assign final_valid = r_final_valid;
`endif

endmodule

// File: tb/tb_rectangle_key_sched_enc.sv
// Bench for rectangle_key_sched_enc: vector table of keys / ready patterns,
// scoreboard queue filled from a reference model, plus reset-mid-run sequence.
module tb_rectangle_key_sched_enc;

  logic        clk = 1'b0;
  logic        rst_n, start, rk_ready;
  logic [79:0] key_in;
  logic        rk_valid, busy, done;
  logic [63:0] rk;
  logic [4:0]  rk_idx;
`ifdef RECT_FINAL_KEY_EN
  logic [79:0] final_key;
  logic        final_valid;
`endif

  rectangle_key_sched_enc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_idx(rk_idx),
    .busy(busy),
`ifdef RECT_FINAL_KEY_EN
    .final_key(final_key), .final_valid(final_valid),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] idx; logic [63:0] rk; } sbe_t;
  typedef struct {
    logic [79:0] key;
    int          pct;
    bit          mid_start;
    bit          chk1;
    logic [63:0] rk1;
  } vec_t;

  sbe_t        sb[$];
  vec_t        vt[5];
  int          n_tests = 0, n_fail = 0;
  logic [79:0] fk_model;
  logic [3:0]  sbt[16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                           4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};
  logic [4:0]  rctab[8] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B, 5'h16};

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference key update, bit by bit.
  function automatic logic [79:0] m_step(input logic [79:0] k, input logic [4:0] rc);
    logic [15:0] r[5];
    logic [15:0] n0, n3;
    logic [3:0]  v;
    for (int i = 0; i < 5; i++) r[i] = k[16*i +: 16];
    for (int j = 0; j < 4; j++) begin
      v = sbt[{r[3][j], r[2][j], r[1][j], r[0][j]}];
      r[0][j] = v[0]; r[1][j] = v[1]; r[2][j] = v[2]; r[3][j] = v[3];
    end
    n0 = ((r[0] << 8) | (r[0] >> 8)) ^ r[1];
    n0[4:0] = n0[4:0] ^ rc;
    n3 = ((r[3] << 12) | (r[3] >> 4)) ^ r[4];
    return {r[0], n3, r[3], r[2], n0};
  endfunction

  function automatic logic [4:0] m_rc(input logic [4:0] rc);
    return {rc[3:0], rc[4] ^ rc[2]};
  endfunction

  task automatic push_sched(input logic [79:0] key);
    logic [79:0] k  = key;
    logic [4:0]  rc = 5'h01;
    for (int i = 0; i < 26; i++) begin
      sb.push_back({5'(i), k[63:0]});
      if (i < 25) begin
        k  = m_step(k, rc);
        rc = m_rc(rc);
      end
    end
    fk_model = k;
  endtask

  // Called at negedge: compare visible round key against scoreboard head,
  // retire it when the handshake will complete at the next edge.
  task automatic mon();
    sbe_t e;
    if (rk_valid) begin
      if (sb.size() == 0) chk("sb_underflow", 80'(rk_idx), 80'h3FF);
      else begin
        e = sb[0];
        chk("rk", 80'(rk), 80'(e.rk));
        chk("rk_idx", 80'(rk_idx), 80'(e.idx));
        if (rk_ready) void'(sb.pop_front());
      end
    end
  endtask

  task automatic run_sched(input vec_t v);
    int cyc = 0, ndone = 0, cyc_done = 0;
    push_sched(v.key);
    key_in   = v.key;
    start    = 1'b1;
    rk_ready = 1'b1;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        chk("busy_after_start", 80'(busy), 80'h1);
        chk("rk0", 80'(rk), 80'(v.key[63:0]));
`ifdef RECT_FINAL_KEY_EN
        chk("final_valid_clr", 80'(final_valid), 80'h0);
`endif
      end
      if (v.mid_start && cyc == 5) begin
        start  = 1'b1;
        key_in = ~v.key;
      end
      if (v.pct >= 100) begin
        if (cyc <= 8) chk($sformatf("rc%0d", cyc - 1), 80'(dut.r_rc), 80'(rctab[cyc-1]));
        if (cyc == 2 && v.chk1) chk("rk1_const", 80'(rk), 80'(v.rk1));
      end
      if (done) begin
        ndone++;
        if (ndone == 1) cyc_done = cyc;
      end else if (ndone > 0) break;
      if (cyc > 2000) begin
        chk("timeout", 80'(cyc), 80'h0);
        break;
      end
      rk_ready = (v.pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < v.pct);
      @(negedge clk);
      mon();
    end
    chk("done_pulses", 80'(ndone), 80'h1);
    chk("busy_end", 80'(busy), 80'h0);
    chk("sb_drained", 80'(sb.size()), 80'h0);
    if (v.pct >= 100) chk("done_cycle", 80'(cyc_done), 80'd27);
`ifdef RECT_FINAL_KEY_EN
    chk("final_key", final_key, fk_model);
    chk("final_valid", 80'(final_valid), 80'h1);
`endif
    sb.delete();
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, 80'(rk_valid), 80'h0);
    chk({nm, "_rk"}, 80'(rk), 80'h0);
    chk({nm, "_idx"}, 80'(rk_idx), 80'h0);
    chk({nm, "_busy"}, 80'(busy), 80'h0);
    chk({nm, "_done"}, 80'(done), 80'h0);
`ifdef RECT_FINAL_KEY_EN
    chk({nm, "_fvalid"}, 80'(final_valid), 80'h0);
`endif
  endtask

  initial begin
    int cyc;
    vec_t rv;
    vt[0] = '{key: 80'h0, pct: 100, mid_start: 0, chk1: 1, rk1: 64'h0000_0000_000F_000E};
    vt[1] = '{key: {80{1'b1}}, pct: 100, mid_start: 0, chk1: 1, rk1: 64'hF000_FFF0_FFF0_0F01};
    vt[2] = '{key: 80'h0123_4567_89AB_CDEF_1357, pct: 50, mid_start: 0, chk1: 0, rk1: 64'h0};
    vt[3] = '{key: 80'hDEAD_BEEF_0BAD_F00D_CAFE, pct: 30, mid_start: 1, chk1: 0, rk1: 64'h0};
    vt[4] = '{key: 80'h8000_0000_0000_0000_0001, pct: 100, mid_start: 1, chk1: 0, rk1: 64'h0};

    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = 80'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_rc", 80'(dut.r_rc), 80'h01);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_sched(vt[i]);

    // Reset while rk_idx == 10, then restart from a fresh key.
    push_sched(80'h5A5A_1234_F0F0_0FF0_AAAA);
    key_in = 80'h5A5A_1234_F0F0_0FF0_AAAA;
    start = 1'b1; rk_ready = 1'b1; cyc = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (rk_valid && rk_idx == 5'd10) break;
      if (cyc > 100) begin
        chk("rst_seq_timeout", 80'(cyc), 80'h0);
        break;
      end
      @(negedge clk);
      mon();
    end
    chk("rst_seq_cycle", 80'(cyc), 80'd11);
    chk("rst_seq_left", 80'(sb.size()), 80'd16);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_idle("midreset");
    chk("midreset_rc", 80'(dut.r_rc), 80'h01);
    sb.delete();
    rst_n = 1'b1;
    rv = '{key: 80'h1111_2222_3333_4444_5555, pct: 100, mid_start: 0, chk1: 0, rk1: 64'h0};
    run_sched(rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rectangle_key_sched_enc.md
Name: rectangle_key_sched_enc

Overview:
- Iterative forward (encryption) key schedule for RECTANGLE-80.
- Accepts an 80-bit master key and emits 26 64-bit round keys (rk0..rk25), one per accepted handshake.
- Sits between the key register and the encryption datapath; it is the forward counterpart of the decryption-side inverse key update.
- Optionally exports the fully-advanced key, which seeds the decryption schedule.

Parameters:
- NR, 25, number of key updates; round keys produced = NR+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  load key_in and begin schedule; honoured only in IDLE
- key_in  input  80  master key
- rk_valid  output  1  rk/rk_idx hold a valid round key
- rk_ready  input  1  consumer accepts current round key
- rk  output  64  round key = current key[63:0], i.e. rows 3..0
- rk_idx  output  5  index of rk, 0..NR
- busy  output  1  high outside IDLE
- done  output  1  one-cycle pulse after rk_NR is accepted

Behaviour:
- Key view: row i = key[16i+15:16i], i = 0..4.
- Update step, combinational, applied on each accepted handshake:
  - S-box: for each column j = 0..3, the 4-bit value {row3[j],row2[j],row1[j],row0[j]} passes through the forward S-box (6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2); result is written back in the same bit order. All other bits pass unchanged.
  - Feistel, using the post-S-box rows: row0' = (row0 <<< 8) ^ row1; row1' = row2; row2' = row3; row3' = (row3 <<< 12) ^ row4; row4' = row0.
  - Constant: row0'[4:0] ^= rc.
- rc: 5-bit LFSR, reset/load value 5'h01. Each step: rc <= {rc[3:0], rc[4]^rc[2]}. Sequence is 01,02,04,09,12,05,0B,...
- FSM states:
  - IDLE: start=1 -> load key_in, rc=01, idx=0, go to RUN.
  - RUN: rk_valid=1. On rk_valid&rk_ready:
    - if idx<NR: update key, advance rc, idx++ (new key is valid the next cycle).
    - if idx==NR: go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Latency: rk0 valid the cycle after start; with rk_ready tied high, one key per cycle and rk_NR on cycle NR+1.
- Backpressure: while rk_ready=0, rk, rk_idx and rk_valid hold stable.
- start while busy is ignored; no restart mid-schedule.
- Reset (any state, including mid-schedule) returns to IDLE: rk_valid=0, rk=0, rk_idx=0, busy=0, done=0, internal key=0, rc=01.

Optional Feature:
- Macro RECT_FINAL_KEY_EN.
- Defined:
  - adds output final_key[79:0] and final_valid.
  - On the last update (idx NR-1 -> NR) the advanced 80-bit key is captured into final_key; final_valid goes high and holds until the next start or reset. Both reset to 0.
- Undefined: ports and capture register are absent; behaviour is otherwise identical.

Decomposition:
- Package rectangle_pkg: RC_INIT=5'h01, NR default, FSM state enum (IDLE/RUN/DONE), forward S-box table constant.
- One sub-module, sbox_enc (4-bit in, 4-bit out), instantiated four times on columns 0..3.

Test Plan:
- Key 80'h0, ready=1 -> rk0 = 64'h0; rk1 = 64'h0000_0000_000F_000E.
- Any key, ready=1 -> rk_idx counts 0..25 on consecutive cycles; done pulses once; internal rc sequence starts 01,02,04,09,12,05,0B,16.
- Toggle rk_ready randomly -> rk and rk_idx stable while ready=0; exactly 26 keys accepted, matching a golden reference model.
- start asserted mid-RUN -> ignored; rk sequence unchanged.
- rst_n low at idx=10 -> next cycle IDLE with all outputs 0; a new start restarts from rk0 = key_in[63:0].
- RECT_FINAL_KEY_EN defined, key 80'h0 -> final_key equals the golden model after 25 updates; final_valid=1 until the next start.
